// File: rtl/dmem_pkg.sv
// Shared encodings and constants for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int   DMEM_BYTES = 'h3000;
  localparam logic PORT_CPU   = 1'b0;
  localparam logic PORT_DBG   = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between the CPU and debug ports.
// DMEM_ARB_RR_EN selects round-robin; otherwise the CPU port has strict priority.
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic [1:0] req_i,
`ifdef DMEM_ARB_RR_EN
  input  logic       rr_last_i,
`endif
  output logic [1:0] pick_o
);

`ifdef DMEM_ARB_RR_EN
  // On a tie the port that was not granted last goes first.
  always_comb begin
    pick_o = req_i;
    if (req_i[PORT_CPU] && req_i[PORT_DBG]) begin
      pick_o = (rr_last_i == PORT_DBG) ? 2'b01 : 2'b10;
    end
  end
`else
  assign pick_o[PORT_CPU] = req_i[PORT_CPU];
  assign pick_o[PORT_DBG] = req_i[PORT_DBG] & ~req_i[PORT_CPU];
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of single-ported data memory.
// Optional round-robin arbitration via DMEM_ARB_RR_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = DMEM_BYTES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rsp_valid,
  output logic              p0_rsp_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rsp_valid,
  output logic              p1_rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              memread,
  output logic              memwrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 4);

  state_e            state_q;
  logic              cmd_port_q, cmd_we_q, cmd_err_q;
  logic              memread_q, memwrite_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, rsp_rdata_q;
  logic [1:0]        rsp_valid_q;
  logic              rsp_err_q;
`ifdef DMEM_ARB_RR_EN
  logic              rr_last_q;
`endif

  logic [1:0]        req_d, pick_d;
  logic              port_d, we_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  assign req_d = {p1_req, p0_req};

  dmem_arb_pick u_pick (
    .req_i     (req_d),
`ifdef DMEM_ARB_RR_EN
    .rr_last_i (rr_last_q),
`endif
    .pick_o    (pick_d)
  );

  // Winner's command and its range/alignment check, evaluated in IDLE.
  always_comb begin
    port_d  = pick_d[PORT_DBG];
    we_d    = port_d ? p1_we    : p0_we;
    addr_d  = port_d ? p1_addr  : p0_addr;
    wdata_d = port_d ? p1_wdata : p0_wdata;
    err_d   = (addr_d[1:0] != 2'b00) || (addr_d > LAST_ADDR);
  end

  assign p0_gnt = ~reset && (state_q == IDLE) && pick_d[PORT_CPU];
  assign p1_gnt = ~reset && (state_q == IDLE) && pick_d[PORT_DBG];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_port_q  <= PORT_CPU;
      cmd_we_q    <= 1'b0;
      cmd_err_q   <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      rr_last_q   <= PORT_DBG;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= 2'b00;
          rsp_err_q   <= 1'b0;
          if (|pick_d) begin
            cmd_port_q  <= port_d;
            cmd_we_q    <= we_d;
            cmd_err_q   <= err_d;
            memwrite_q  <= ~err_d & we_d;
            memread_q   <= ~err_d & ~we_d;
            mem_addr_q  <= err_d ? '0 : addr_d;
            mem_wdata_q <= err_d ? '0 : wdata_d;
`ifdef DMEM_ARB_RR_EN
            rr_last_q   <= port_d;
`endif
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          memread_q   <= 1'b0;
          memwrite_q  <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          rsp_rdata_q <= (~cmd_err_q & ~cmd_we_q) ? mem_rdata : '0;
          rsp_valid_q <= (cmd_port_q == PORT_DBG) ? 2'b10 : 2'b01;
          rsp_err_q   <= cmd_err_q;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 2'b00;
          rsp_err_q   <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memread      = memread_q;
  assign memwrite     = memwrite_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign p0_rsp_valid = rsp_valid_q[PORT_CPU];
  assign p1_rsp_valid = rsp_valid_q[PORT_DBG];
  assign p0_rsp_err   = rsp_err_q & rsp_valid_q[PORT_CPU];
  assign p1_rsp_err   = rsp_err_q & rsp_valid_q[PORT_DBG];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic        p0_gnt, p0_rsp_valid, p0_rsp_err;
  logic        p1_gnt, p1_rsp_valid, p1_rsp_err;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        memread, memwrite;

  always #5 clock = ~clock;

  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_err(p0_rsp_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_err(p1_rsp_err),
    .rsp_rdata(rsp_rdata), .memread(memread), .memwrite(memwrite),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory model: asynchronous read, write on the clock edge.
  logic [31:0] mem [0:4095];
  assign mem_rdata = memread ? mem[mem_addr[13:2]] : 32'h0;
  always @(posedge clock) if (memwrite) mem[mem_addr[13:2]] <= mem_wdata;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t sb[$];
  rsp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_port(input bit port, input bit req, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  task automatic check_idle(input string name);
    check32({name, "_ctl"}, {24'h0, p0_gnt, p0_rsp_valid, p0_rsp_err, p1_gnt,
                             p1_rsp_valid, p1_rsp_err, memread, memwrite}, 32'h0);
    check32({name, "_rdata"}, rsp_rdata, 32'h0);
    check32({name, "_maddr"}, mem_addr, 32'h0);
    check32({name, "_mwdata"}, mem_wdata, 32'h0);
  endtask

  // Waits (bounded) for the given port's grant; called just after a falling edge.
  task automatic wait_gnt(input bit port, output bit got);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (port ? p1_gnt : p0_gnt) got = 1;
      else @(negedge clock);
    end
    check1("gnt_seen", got, 1'b1);
    if (got) check1("gnt_excl", p0_gnt & p1_gnt, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    rsp_t e;
    bit   got;
    @(negedge clock);
    set_port(v.port, 1, v.we, v.addr, v.wdata);
    wait_gnt(v.port, got);
    if (!got) begin
      set_port(v.port, 0, 0, 0, 0);
      return;
    end
    e.port = v.port; e.err = v.exp_err; e.rdata = v.exp_rdata;
    sb.push_back(e);
    $display("[TB] txn port=%0d we=%0d addr=%h wdata=%h exp_err=%0d exp_rdata=%h",
             v.port, v.we, v.addr, v.wdata, v.exp_err, v.exp_rdata);
    @(negedge clock);
    set_port(v.port, 0, 0, 0, 0);
    check1("issue_memwrite", memwrite, v.we & ~v.exp_err);
    check1("issue_memread", memread, ~v.we & ~v.exp_err);
    if (!v.exp_err) check32("issue_maddr", mem_addr, v.addr);
    if (!v.exp_err && v.we) check32("issue_mwdata", mem_wdata, v.wdata);
    @(negedge clock);
    check1("rsp_at_t2", v.port ? p1_rsp_valid : p0_rsp_valid, 1'b1);
  endtask

  // Response scoreboard and bus-level invariants.
  always @(negedge clock) begin
    if (!reset) begin
      check1("strobe_excl", memread & memwrite, 1'b0);
      if (!memread && !memwrite) check32("idle_maddr", mem_addr, 32'h0);
      if (p0_rsp_valid || p1_rsp_valid) begin
        check1("rsp_excl", p0_rsp_valid & p1_rsp_valid, 1'b0);
        if (sb.size() == 0) begin
          check1("unexpected_rsp", 1'b1, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check1("rsp_port", p1_rsp_valid, mon_e.port);
          check1("rsp_err", p1_rsp_valid ? p1_rsp_err : p0_rsp_err, mon_e.err);
          check32("rsp_rdata", rsp_rdata, mon_e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  vec_t tbl [10];
  bit   exp_ord [5];
  bit   got;
  rsp_t e;

  initial begin
    tbl[0] = '{0, 1, 32'h0000_0000, 32'h1111_1111, 0, 32'h0};
    tbl[1] = '{0, 0, 32'h0000_0000, 32'h0,         0, 32'h1111_1111};
    tbl[2] = '{1, 1, 32'h0000_0100, 32'h1234_5678, 0, 32'h0};
    tbl[3] = '{0, 0, 32'h0000_0100, 32'h0,         0, 32'h1234_5678};
    tbl[4] = '{0, 0, 32'h0000_0002, 32'h0,         1, 32'h0};
    tbl[5] = '{0, 1, 32'h0000_2FFC, 32'hDEAD_BEEF, 0, 32'h0};
    tbl[6] = '{1, 1, 32'h0000_3000, 32'hCAFE_F00D, 1, 32'h0};
    tbl[7] = '{0, 0, 32'h0000_2FFC, 32'h0,         0, 32'hDEAD_BEEF};
    tbl[8] = '{1, 0, 32'h0000_2FFC, 32'h0,         0, 32'hDEAD_BEEF};
    tbl[9] = '{1, 0, 32'h0000_0003, 32'h0,         1, 32'h0};
`ifdef DMEM_ARB_RR_EN
    exp_ord = '{0, 1, 0, 1, 1};
`else
    exp_ord = '{0, 0, 0, 0, 1};
`endif

    repeat (3) @(negedge clock);
    check_idle("reset_hold");
    reset = 1'b0;
    @(negedge clock);
    check_idle("after_reset");

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    // Both ports requesting continuously; port 0 drops out after four grants.
    @(negedge clock);
    set_port(0, 1, 0, 32'h0, 32'h0);
    set_port(1, 1, 0, 32'h100, 32'h0);
    for (int k = 0; k < 5; k++) begin
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        #1;
        if (p0_gnt || p1_gnt) got = 1;
        else @(negedge clock);
      end
      check1("tie_gnt_seen", got, 1'b1);
      if (!got) break;
      check1("tie_gnt_excl", p0_gnt & p1_gnt, 1'b0);
      check1("tie_order", p1_gnt, exp_ord[k]);
      e.port = p1_gnt; e.err = 0; e.rdata = p1_gnt ? 32'h1234_5678 : 32'h1111_1111;
      sb.push_back(e);
      $display("[TB] txn tie k=%0d granted port=%0d", k, p1_gnt);
      @(negedge clock);
      if (k == 3) set_port(0, 0, 0, 0, 0);
      if (k == 4) set_port(1, 0, 0, 0, 0);
      @(negedge clock);
      @(negedge clock);
    end
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);

    // Reset while a port-0 read is in ISSUE: the transaction vanishes.
    @(negedge clock);
    set_port(0, 1, 0, 32'h0, 32'h0);
    wait_gnt(0, got);
    $display("[TB] txn reset-mid-issue port=0 read addr=00000000");
    @(negedge clock);
    check1("rst_issue_memread", memread, 1'b1);
    set_port(0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clock);
    check_idle("rst_mid");
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      #1;
      check1("rst_no_rsp", p0_rsp_valid, 1'b0);
    end
    run_vec('{0, 0, 32'h0, 32'h0, 0, 32'h1111_1111});

    // Port 1 requests while busy and withdraws before the arbiter returns to IDLE.
    @(negedge clock);
    set_port(0, 1, 1, 32'h200, 32'hA5A5_A5A5);
    wait_gnt(0, got);
    e.port = 0; e.err = 0; e.rdata = 32'h0;
    if (got) sb.push_back(e);
    $display("[TB] txn withdraw port=0 write addr=00000200");
    @(negedge clock);
    set_port(0, 0, 0, 0, 0);
    set_port(1, 1, 0, 32'h0, 32'h0);
    #1;
    check1("busy_issue_no_gnt1", p1_gnt, 1'b0);
    @(negedge clock);
    #1;
    check1("busy_resp_no_gnt1", p1_gnt, 1'b0);
    set_port(1, 0, 0, 0, 0);
    repeat (4) begin
      @(negedge clock);
      #1;
      check1("withdraw_no_gnt1", p1_gnt, 1'b0);
      check1("withdraw_no_rsp1", p1_rsp_valid, 1'b0);
    end
    run_vec('{1, 0, 32'h200, 32'h0, 0, 32'hA5A5_A5A5});

    repeat (3) @(negedge clock);
    check32("sb_drained", sb.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
